mantissa_divider: RTL and testbench

//  Sequential unsigned mantissa divider for the FP divide path. It is the inverse of the mantissa multiplier.

---
 rtl/mantissa_divider_pkg.sv | 23 ++
 rtl/mantissa_div_step.sv | 25 ++
 rtl/mantissa_divider.sv | 124 ++++++++++++
 tb/tb_mantissa_divider.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mantissa_divider_pkg.sv
// Shared definitions for the FP mantissa datapath: default fraction width, divider FSM
// encodings and the counter-width helper also used by the mantissa multiplier.
package mantissa_divider_pkg;

   localparam int unsigned DefBitWidth = 23;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Smallest width (at least 1) whose range covers 0..n-1.
   function automatic int unsigned bit_cnt_func(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/mantissa_div_step.sv
// One restoring-division step: compare the partial remainder against the divisor,
// subtract when it fits, and shift the result left for the next quotient bit.
module mantissa_div_step
   import mantissa_divider_pkg::*;
#(
   parameter int unsigned BitWidth = DefBitWidth
) (
   input  logic [BitWidth+1:0] r_i,
   input  logic [BitWidth:0]   b_i,
   output logic                qbit_o,
   output logic [BitWidth+1:0] r_next_o
);

   logic              ge;
   logic [BitWidth:0] rem;

   always_comb begin
      ge = (r_i >= {1'b0, b_i});
      // The reduced remainder is always below the divisor, so its top bit can be dropped.
      rem      = ge ? (r_i[BitWidth:0] - b_i) : r_i[BitWidth:0];
      qbit_o   = ge;
      r_next_o = {rem, 1'b0};
   end

endmodule

// File: rtl/mantissa_divider.sv
// Sequential restoring divider for {1,in0}/{1,in1}: one quotient bit per clock, truncated,
// with a normalise flag for the exponent path and a sticky bit for later rounding.
module mantissa_divider
   import mantissa_divider_pkg::*;
#(
   parameter int unsigned BitWidth = DefBitWidth
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [BitWidth-1:0] in0_i,
   input  logic [BitWidth-1:0] in1_i,
   output logic                out_valid_o,
   output logic [BitWidth-1:0] out_o,
   output logic                norm_o,
   output logic                sticky_o
);

   localparam int unsigned N       = BitWidth + 2;
   localparam int unsigned CntW    = bit_cnt_func(N);
   localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [N-1:0]        r_q, r_d;
   logic [N-2:0]        q_q, q_d;
   logic [BitWidth:0]   b_q, b_d;
   logic [BitWidth-1:0] out_q, out_d;
   logic                norm_q, norm_d;
   logic                sticky_q, sticky_d;

   logic                qbit;
   logic [N-1:0]        r_step;
   logic [N-1:0]        q_full;

   mantissa_div_step #(
      .BitWidth (BitWidth)
   ) u_step (
      .r_i      (r_q),
      .b_i      (b_q),
      .qbit_o   (qbit),
      .r_next_o (r_step)
   );

   // Full quotient including the bit produced this cycle; complete only on the last step.
   assign q_full = {q_q, qbit};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      r_d      = r_q;
      q_d      = q_q;
      b_d      = b_q;
      out_d    = out_q;
      norm_d   = norm_q;
      sticky_d = sticky_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               b_d     = {1'b1, in1_i};
               r_d     = {1'b0, 1'b1, in0_i};
               q_d     = '0;
               cnt_d   = CntLast;
               state_d = StRun;
            end
         end
         StRun: begin
            r_d = r_step;
            q_d = q_full[N-2:0];
            if (cnt_q == '0) begin
               state_d = StDone;
               if (q_full[N-1]) begin
                  out_d    = q_full[BitWidth:1];
                  norm_d   = 1'b0;
                  sticky_d = (|r_step) | q_full[0];
               end else begin
                  out_d    = q_full[BitWidth-1:0];
                  norm_d   = 1'b1;
                  sticky_d = |r_step;
               end
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         r_q      <= '0;
         q_q      <= '0;
         b_q      <= '0;
         out_q    <= '0;
         norm_q   <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         r_q      <= r_d;
         q_q      <= q_d;
         b_q      <= b_d;
         out_q    <= out_d;
         norm_q   <= norm_d;
         sticky_q <= sticky_d;
      end
   end

   assign in_ready_o  = (state_q == StIdle);
   assign out_valid_o = (state_q == StDone);
   assign out_o       = out_q;
   assign norm_o      = norm_q;
   assign sticky_o    = sticky_q;

endmodule

// File: tb/tb_mantissa_divider.sv
// Bench for mantissa_divider: an arithmetic reference model checked every cycle, plus
// directed operands with hand-computed results, mid-operation reset and back-to-back traffic.
module tb_mantissa_divider;

   localparam int unsigned BW     = 23;
   localparam int unsigned N      = BW + 2;
   localparam int unsigned Lat    = N;
   localparam int unsigned Period = N + 2;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] in0;
   logic [BW-1:0] in1;
   logic          out_valid;
   logic [BW-1:0] out;
   logic          norm;
   logic          sticky;

   int n_vec  = 0;
   int n_fail = 0;

   mantissa_divider #(
      .BitWidth (BW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in0_i       (in0),
      .in1_i       (in1),
      .out_valid_o (out_valid),
      .out_o       (out),
      .norm_o      (norm),
      .sticky_o    (sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Result packed as {norm, sticky, out}, from floor((A << N-1) / B).
   function automatic logic [BW+1:0] ref_div(input logic [BW-1:0] a, input logic [BW-1:0] b);
      logic [63:0] num, den, q, r;
      num = {40'd0, 1'b1, a} << (N - 1);
      den = {40'd0, 1'b1, b};
      q   = num / den;
      r   = num % den;
      if (q[N-1]) return {1'b0, (r != 0) || q[0], q[BW:1]};
      else        return {1'b1, (r != 0), q[BW-1:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: busy for Lat+1 edges after an accept; result visible for one cycle at Lat.
   int            m_busy  = 0;
   logic          m_valid = 1'b0;
   logic [BW+1:0] m_res   = '0;
   logic [BW+1:0] m_pend  = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  = 0;
         m_valid = 1'b0;
         m_res   = '0;
         m_pend  = '0;
      end else begin
         m_valid = 1'b0;
         if (m_busy == 0) begin
            if (in_valid) begin
               m_pend = ref_div(in0, in1);
               m_busy = Lat + 1;
            end
         end else begin
            m_busy--;
            if (m_busy == 1) begin
               m_valid = 1'b1;
               m_res   = m_pend;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, m_busy == 0);
      chk("out_valid", out_valid, m_valid);
      chk("result", {norm, sticky, out}, m_res);
   end

   // Applies one op, scrambles the operand pins while it runs, returns accept-to-valid cycles.
   task automatic run_op(input logic [BW-1:0] a, input logic [BW-1:0] b, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      in0      = a;
      in1      = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in0      = ~a;
      in1      = b ^ 23'h5A5A5A;
      lat      = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic dir(input logic [BW-1:0] a, input logic [BW-1:0] b,
                      input logic [BW-1:0] e_out, input logic e_norm, input logic e_sticky);
      int lat;
      chk("model_pin", ref_div(a, b), {e_norm, e_sticky, e_out});
      run_op(a, b, lat);
      chk("latency", lat, Lat);
      chk("out", out, e_out);
      chk("norm", norm, e_norm);
      chk("sticky", sticky, e_sticky);
   endtask

   logic [BW-1:0] bb_a [3];
   logic [BW-1:0] bb_b [3];
   int            t_valid [$];
   int            seen;
   int            lat;
   logic [BW-1:0] ra, rb;

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in0      = '0;
      in1      = '0;
      repeat (3) @(negedge clk);
      chk("reset_ready", in_ready, 1'b1);
      chk("reset_outs", {out_valid, norm, sticky, out}, '0);
      rst_n = 1'b1;

      dir(23'h400000, 23'h000000, 23'h400000, 1'b0, 1'b0);
      dir(23'h000000, 23'h400000, 23'h2AAAAA, 1'b1, 1'b1);
      dir(23'h000000, 23'h000000, 23'h000000, 1'b0, 1'b0);
      dir(23'h7FFFFF, 23'h7FFFFF, 23'h000000, 1'b0, 1'b0);
      dir(23'h000000, 23'h7FFFFF, 23'h000000, 1'b1, 1'b1);
      dir(23'h7FFFFF, 23'h000000, 23'h7FFFFF, 1'b0, 1'b0);
      dir(23'h400000, 23'h000000, 23'h400000, 1'b0, 1'b0);

      // Reset ten cycles into an operation.
      @(negedge clk);
      in0      = 23'h000000;
      in1      = 23'h400000;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_outs", {out_valid, norm, sticky, out}, '0);
      seen = 0;
      repeat (Period + 5) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("rst_no_valid", seen, 0);
      dir(23'h7FFFFF, 23'h000000, 23'h7FFFFF, 1'b0, 1'b0);

      // in_valid held high across three ops.
      bb_a[0] = 23'h400000; bb_b[0] = 23'h000000;
      bb_a[1] = 23'h000000; bb_b[1] = 23'h400000;
      bb_a[2] = 23'h7FFFFF; bb_b[2] = 23'h7FFFFF;
      @(negedge clk);
      seen = 0;
      while (!in_ready && seen < 100) begin
         @(negedge clk);
         seen++;
      end
      in0      = bb_a[0];
      in1      = bb_b[0];
      in_valid = 1'b1;
      for (int i = 1; i <= 85; i++) begin
         @(negedge clk);
         if (i % 27 == 0 && i < 81) begin
            in0 = bb_a[i / 27];
            in1 = bb_b[i / 27];
         end
         if (i == 55) in_valid = 1'b0;
         if (out_valid) t_valid.push_back(i);
      end
      chk("bb_count", t_valid.size(), 3);
      if (t_valid.size() == 3) begin
         chk("bb_first", t_valid[0], Lat + 1);
         chk("bb_gap1", t_valid[1] - t_valid[0], Period);
         chk("bb_gap2", t_valid[2] - t_valid[1], Period);
      end

      // Random operands; results also checked every cycle against the model.
      for (int k = 0; k < 300; k++) begin
         ra = BW'($urandom);
         rb = BW'($urandom);
         run_op(ra, rb, lat);
         chk("rand_lat", lat, Lat);
         chk("rand_res", {norm, sticky, out}, ref_div(ra, rb));
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
